// File: rtl/msg_buf_ctrl.sv
// Ping-pong sequencer for the 128-byte SHA-256 message register file: bytes are
// written into a free 64-byte bank while the other bank streams out as 16 big-endian words.
module msg_buf_ctrl #(
  parameter int         BLK_BYTES = 64,
  parameter logic [7:0] PARK_ADDR = 8'd255,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       rf_data,
  output logic [7:0]       rf_addr_wr,
  output logic [4:0]       rf_addr_rd,
  input  logic [31:0]      rf_data_rd,
  output logic [31:0]      w_data,
  output logic             w_valid,
  input  logic             w_ready,
  output logic             w_last,
  output logic [1:0]       bank_full,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FULL    = 2'd1,
    B_READING = 2'd2
  } bank_st_e;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } rd_st_e;

  bank_st_e         bank_st_r [2];
  logic             fill_bank_r;
  logic [5:0]       byte_cnt_r;
  logic             rd_bank_r;
  logic [3:0]       word_cnt_r;
  rd_st_e           rd_st_r;
  logic             w_valid_r;
  logic             w_last_r;
  logic [CNT_W-1:0] blk_cnt_r;
  logic             in_ready_s;
  logic             wr_acc_s;

  // Write-side handshake; an idle cycle parks the address outside the file
  always_comb begin
    in_ready_s = 1'b0;
    wr_acc_s   = 1'b0;
    rf_addr_wr = PARK_ADDR;
    rf_data    = 8'd0;
    if (rst && !clr && (bank_st_r[fill_bank_r] == B_EMPTY)) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    wr_acc_s = in_valid && in_ready_s;
    if (wr_acc_s) begin
      rf_addr_wr = {1'b0, fill_bank_r, byte_cnt_r};
      rf_data    = in_data;
    end else begin
      rf_addr_wr = PARK_ADDR;
      rf_data    = 8'd0;
    end
  end

  assign in_ready   = in_ready_s;
  assign rf_addr_rd = {rd_bank_r, word_cnt_r};
  assign w_data     = rf_data_rd;
  assign w_valid    = w_valid_r;
  assign w_last     = w_last_r;
  assign bank_full  = {bank_st_r[1] != B_EMPTY, bank_st_r[0] != B_EMPTY};
  assign blk_cnt    = blk_cnt_r;

  // Bank fill tracking and read stream sequencer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_st_r[0] <= B_EMPTY;
      bank_st_r[1] <= B_EMPTY;
      fill_bank_r  <= 1'b0;
      byte_cnt_r   <= 6'd0;
      rd_bank_r    <= 1'b0;
      word_cnt_r   <= 4'd0;
      rd_st_r      <= R_IDLE;
      w_valid_r    <= 1'b0;
      w_last_r     <= 1'b0;
      blk_cnt_r    <= '0;
    end else if (clr) begin
      bank_st_r[0] <= B_EMPTY;
      bank_st_r[1] <= B_EMPTY;
      fill_bank_r  <= 1'b0;
      byte_cnt_r   <= 6'd0;
      rd_bank_r    <= 1'b0;
      word_cnt_r   <= 4'd0;
      rd_st_r      <= R_IDLE;
      w_valid_r    <= 1'b0;
      w_last_r     <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        byte_cnt_r <= byte_cnt_r + 6'd1;
        if (byte_cnt_r == 6'(BLK_BYTES - 1)) begin
          bank_st_r[fill_bank_r] <= B_FULL;
          fill_bank_r            <= ~fill_bank_r;
        end
      end
      // Writes only ever target an EMPTY bank, so the two sides never touch the same entry
      case (rd_st_r)
        R_IDLE: begin
          if (bank_st_r[rd_bank_r] == B_FULL) begin
            bank_st_r[rd_bank_r] <= B_READING;
            rd_st_r              <= R_STREAM;
            w_valid_r            <= 1'b1;
            w_last_r             <= 1'b0;
          end
        end
        R_STREAM: begin
          if (w_ready) begin
            word_cnt_r <= word_cnt_r + 4'd1;
            w_last_r   <= (word_cnt_r == 4'd14);
            if (word_cnt_r == 4'd15) begin
              bank_st_r[rd_bank_r] <= B_EMPTY;
              rd_bank_r            <= ~rd_bank_r;
              blk_cnt_r            <= blk_cnt_r + 1'b1;
              rd_st_r              <= R_IDLE;
              w_valid_r            <= 1'b0;
              w_last_r             <= 1'b0;
            end
          end
        end
        default: begin
          rd_st_r   <= R_IDLE;
          w_valid_r <= 1'b0;
          w_last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_buf_ctrl.sv
// Scoreboard bench for msg_buf_ctrl: a register-file model plus a byte/word
// scoreboard checked on every falling edge, with directed checks around each scenario.
module tb_msg_buf_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  rf_data;
  logic [7:0]  rf_addr_wr;
  logic [4:0]  rf_addr_rd;
  logic [31:0] rf_data_rd;
  logic [31:0] w_data;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic        w_last;
  logic [1:0]  bank_full;
  logic [15:0] blk_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  msg_buf_ctrl dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rf_data(rf_data), .rf_addr_wr(rf_addr_wr), .rf_addr_rd(rf_addr_rd),
    .rf_data_rd(rf_data_rd), .w_data(w_data), .w_valid(w_valid),
    .w_ready(w_ready), .w_last(w_last), .bank_full(bank_full), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  // Register file: unconditional byte write, combinational big-endian word read
  logic [7:0] rf_mem [128];
  always @(posedge clk) begin
    if (!rf_addr_wr[7]) rf_mem[rf_addr_wr[6:0]] <= rf_data;
  end
  assign rf_data_rd = {rf_mem[{rf_addr_rd, 2'b00}], rf_mem[{rf_addr_rd, 2'b01}],
                       rf_mem[{rf_addr_rd, 2'b10}], rf_mem[{rf_addr_rd, 2'b11}]};

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard state: expected words are {last, data}
  logic [32:0] exp_w_q [$];
  logic [7:0]  blk_buf [64];
  int          m_cnt;
  logic        m_fill;
  logic        m_rd_bank;
  logic [3:0]  m_word;
  logic [15:0] m_blk;
  logic        prev_hold;
  logic [31:0] prev_data;
  logic [4:0]  prev_addr;
  logic        prev_last;

  task automatic flush_model();
    exp_w_q.delete();
    m_cnt = 0; m_fill = 1'b0; m_rd_bank = 1'b0; m_word = 4'd0; prev_hold = 1'b0;
  endtask

  initial begin
    logic [32:0] e;
    m_blk = 16'd0;
    flush_model();
    forever begin
      @(negedge clk);
      if (!rst) begin
        flush_model();
        m_blk = 16'd0;
      end else begin
        check_eq("blk_cnt", blk_cnt, m_blk);
        if (prev_hold) begin
          check_eq("hold_data", w_data, prev_data);
          check_eq("hold_addr", rf_addr_rd, prev_addr);
          check_eq("hold_last", w_last, prev_last);
        end
        if (clr) begin
          check_eq("clr_in_ready", in_ready, 1'b0);
          flush_model();
        end else begin
          if (in_valid && in_ready) begin
            check_eq("wr_addr", rf_addr_wr, {1'b0, m_fill, 6'(m_cnt)});
            check_eq("wr_data", rf_data, in_data);
            blk_buf[m_cnt] = in_data;
            m_cnt++;
            if (m_cnt == 64) begin
              for (int k = 0; k < 16; k++)
                exp_w_q.push_back({(k == 15), blk_buf[4*k], blk_buf[4*k+1], blk_buf[4*k+2], blk_buf[4*k+3]});
              m_cnt = 0;
              m_fill = ~m_fill;
            end
          end else begin
            check_eq("park", rf_addr_wr, 8'd255);
          end
          if (w_valid) begin
            check_eq("rd_addr", rf_addr_rd, {m_rd_bank, m_word});
            if (w_ready) begin
              if (exp_w_q.size() == 0) begin
                check_eq("unexp_word", 1'b1, 1'b0);
              end else begin
                e = exp_w_q.pop_front();
                check_eq("w_data", w_data, e[31:0]);
                check_eq("w_last", w_last, e[32]);
              end
              if (m_word == 4'd15) begin
                m_word = 4'd0; m_rd_bank = ~m_rd_bank; m_blk = m_blk + 16'd1;
              end else begin
                m_word = m_word + 4'd1;
              end
            end
          end
          prev_hold = w_valid && !w_ready;
          prev_data = w_data; prev_addr = rf_addr_rd; prev_last = w_last;
        end
      end
    end
  end

  task automatic send_bytes(input int n, input logic [7:0] base);
    logic acc;
    int   cyc;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      acc = 1'b0; cyc = 0;
      while (!acc) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1;
        cyc++;
        if (!acc && cyc > 2000) begin
          check_eq("send_timeout", 1'b0, 1'b1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (exp_w_q.size() == 0 && !w_valid) return;
    end
    check_eq("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200; i++) begin
      if (w_valid) return;
      @(posedge clk); #1;
    end
    check_eq("valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_last();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (w_valid && w_ready && w_last) return;
    end
    check_eq("last_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    // Reset values, with a byte offered to prove in_ready stays low
    in_valid = 1'b1; in_data = 8'hA5;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_w_valid", w_valid, 1'b0);
    check_eq("rst_w_last", w_last, 1'b0);
    check_eq("rst_bank_full", bank_full, 2'b00);
    check_eq("rst_blk_cnt", blk_cnt, 16'd0);
    check_eq("rst_park", rf_addr_wr, 8'd255);
    check_eq("rst_rd_addr", rf_addr_rd, 5'd0);
    check_eq("rst_rf_data", rf_data, 8'd0);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;

    // First block and its two-cycle read latency
    send_bytes(64, 8'h00);
    check_eq("lat_valid0", w_valid, 1'b0);
    @(posedge clk); #1;
    check_eq("lat_valid1", w_valid, 1'b1);
    check_eq("lat_w0", w_data, 32'h00010203);
    check_eq("lat_addr0", rf_addr_rd, 5'd0);
    wait_drain();
    check_eq("blk1", blk_cnt, 16'd1);

    // Both banks full under back-pressure, then release
    w_ready = 1'b0;
    send_bytes(128, 8'h40);
    check_eq("bp_in_ready", in_ready, 1'b0);
    check_eq("bp_bank_full", bank_full, 2'b11);
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp_valid", w_valid, 1'b1);
    check_eq("bp_w0", w_data, 32'h40414243);
    fork
      send_bytes(64, 8'hC0);
      begin
        w_ready = 1'b1;
        wait_last();
        check_eq("w15_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        check_eq("freed_in_ready", in_ready, 1'b1);
      end
    join
    wait_drain();
    check_eq("blk4", blk_cnt, 16'd4);

    // Stuttering consumer
    fork
      send_bytes(64, 8'h10);
      for (int i = 0; i < 120; i++) begin
        @(posedge clk); #1;
        w_ready = i[1];
      end
    join
    w_ready = 1'b1;
    wait_drain();
    check_eq("blk5", blk_cnt, 16'd5);

    // Idle bus parks the write address
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check_eq("idle_park", rf_addr_wr, 8'd255);
    end

    // Flush after a partial block
    send_bytes(20, 8'h20);
    in_valid = 1'b1; in_data = 8'hEE; clr = 1'b1;
    #1;
    check_eq("clr_cycle_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    check_eq("clr_bank_full", bank_full, 2'b00);
    check_eq("clr_w_valid", w_valid, 1'b0);
    check_eq("clr_keep_blk", blk_cnt, 16'd5);

    // 64th byte into bank 1 coincides with W15 accepted from bank 0
    w_ready = 1'b0;
    send_bytes(64, 8'h80);
    send_bytes(63, 8'h01);
    wait_valid();
    w_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    w_ready = 1'b0;
    check_eq("coin_w15", w_last, 1'b1);
    in_valid = 1'b1; in_data = 8'h40; w_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("coin_bank_full", bank_full, 2'b10);
    check_eq("coin_blk", blk_cnt, 16'd6);
    check_eq("coin_in_ready", in_ready, 1'b1);
    check_eq("coin_gap", w_valid, 1'b0);
    @(posedge clk); #1;
    check_eq("coin_b1_valid", w_valid, 1'b1);
    check_eq("coin_b1_w0", w_data, 32'h01020304);
    wait_drain();
    check_eq("blk7", blk_cnt, 16'd7);

    // Reset mid-stream, then recover
    w_ready = 1'b0;
    send_bytes(64, 8'h30);
    wait_valid();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", w_valid, 1'b0);
    check_eq("mid_rst_blk", blk_cnt, 16'd0);
    check_eq("mid_rst_full", bank_full, 2'b00);
    @(posedge clk); #1;
    rst = 1'b1; w_ready = 1'b1;
    send_bytes(64, 8'h55);
    wait_drain();
    check_eq("post_rst_blk", blk_cnt, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_buf_ctrl.md
Name: msg_buf_ctrl

Overview:
- Sequencer for the 128-byte byte-write / 32-bit-read message register file that feeds the SHA-256 message scheduler.
- Treats the file as two 64-byte ping-pong banks: bank 0 is bytes 0-63 / words 0-15; bank 1 is bytes 64-127 / words 16-31.
- Accepts a byte stream through a valid/ready handshake and writes each 64-byte block into a free bank.
- Streams each full bank out as 16 big-endian words W0..W15 through a second valid/ready handshake, so the loader and the compressor overlap.

Parameters:
- BLK_BYTES, 64, bytes per bank; fixed at 64, other values unsupported.
- PARK_ADDR, 8'd255, write address driven when no byte is being written; outside the 128-entry file.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush; empties both banks and aborts any stream.
- in_data  in  8  message byte.
- in_valid  in  1  byte offered.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- rf_data  out  8  byte to the register file write port.
- rf_addr_wr  out  8  register file write address.
- rf_addr_rd  out  5  register file word read address.
- rf_data_rd  in  32  combinational read data from the register file.
- w_data  out  32  message word to the scheduler; equals rf_data_rd.
- w_valid  out  1  word offered.
- w_ready  in  1  scheduler accepts the word.
- w_last  out  1  high with W15 of a block.
- bank_full  out  2  per-bank full flag, bit b = bank b.
- blk_cnt  out  CNT_W  blocks fully streamed out; wraps modulo 2^CNT_W.

Behaviour:
- Reset values (rst low, asynchronous):
  - Both banks EMPTY; fill_bank=0, byte_cnt=0, rd_bank=0, word_cnt=0, read FSM in R_IDLE.
  - in_ready=0 while rst is low.
  - w_valid=0, w_last=0, bank_full=2'b00, blk_cnt=0.
  - rf_addr_wr=PARK_ADDR, rf_addr_rd=0, rf_data=0.
- Per-bank state: EMPTY -> FULL -> READING -> EMPTY.
- Write side:
  - in_ready = (bank[fill_bank]==EMPTY), combinational.
  - Each accept writes combinationally in the same cycle: rf_addr_wr = fill_bank*64 + byte_cnt, rf_data = in_data.
  - byte_cnt increments on every accept.
  - On the 64th accept (byte_cnt==63): bank becomes FULL next cycle, fill_bank toggles, byte_cnt wraps to 0.
  - With no accept, rf_addr_wr=PARK_ADDR so the file's unconditional write is discarded.
- Read FSM:
  - R_IDLE: if bank[rd_bank]==FULL, move to R_STREAM next cycle and mark the bank READING. This is 1 cycle of latency from FULL.
  - R_STREAM: rf_addr_rd = rd_bank*16 + word_cnt; w_valid=1; w_data=rf_data_rd in the same cycle.
  - Byte ordering: word k = {byte 4k, 4k+1, 4k+2, 4k+3}, big-endian.
  - w_valid && !w_ready: rf_addr_rd, w_data and w_last hold stable.
  - On accept: word_cnt increments.
  - On accept with word_cnt==15 (w_last=1): bank becomes EMPTY next cycle, rd_bank toggles, word_cnt=0, blk_cnt+1, return to R_IDLE.
  - Between consecutive blocks there is at least 1 cycle with w_valid=0.
- bank_full[b] = 1 when bank b is FULL or READING.
- Simultaneous events:
  - A 64th byte written into one bank and W15 accepted from the other bank in the same cycle: both transitions take effect.
  - A bank freed by W15 shows in_ready=1 the following cycle, never the same cycle.
- clr: takes priority over all handshakes in its cycle.
  - Next cycle: both banks EMPTY, pointers and counters 0 except blk_cnt (retained), R_IDLE, w_valid=0.
  - No bytes are accepted in the clr cycle (in_ready forced 0).
- rst asserted mid-block: state is immediately reset values; partially written bytes are abandoned; the register file is not cleared.
- Concurrent write and read of the same bank is impossible: writes only target EMPTY banks.

Test Plan:
- Reset, then feed 64 bytes 0x00..0x3F with in_valid held high -> rf_addr_wr 0..63 on consecutive cycles. Two cycles after the last byte, w_valid=1 with w_data=0x00010203 and rf_addr_rd=0. W15=0x3C3D3E3F with w_last=1. blk_cnt=1.
- Feed 192 bytes back-to-back with w_ready=0 -> in_ready drops after byte 128 and bank_full=2'b11. Raise w_ready -> bank 0 words stream, in_ready returns 1 cycle after W15 accepted, and byte 129 is written at address 0.
- Toggle w_ready every other cycle during a stream -> each word is held until accepted. Exactly 16 accepts per block, with w_last only on the 16th.
- Arrange the 64th byte into bank 1 to coincide with W15 accept from bank 0 -> next cycle bank 0 EMPTY, bank 1 enters READING, blk_cnt increments, no lost byte.
- Idle with in_valid=0 -> rf_addr_wr=255 every cycle.
- Assert clr after 20 bytes, then send 64 new bytes -> the new bytes land at addresses 0..63 and stream correctly.
- Assert rst mid-stream -> w_valid=0 immediately and blk_cnt=0.
